// File: rtl/cv32e40s_pkg.sv
// Shared types, constants and RV32I encoding helpers for the Zcmp sequencer.
// No ports; imported by the interface, decoder and sequencer top.
package cv32e40s_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned IMM_W   = 12;

    localparam logic [6:0] OPCODE_STORE = 7'h23;
    localparam logic [6:0] OPCODE_LOAD  = 7'h03;
    localparam logic [6:0] OPCODE_OPIMM = 7'h13;
    localparam logic [6:0] OPCODE_JALR  = 7'h67;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_W-1:0] REG_RA   = 5'd1;
    localparam logic [REG_W-1:0] REG_SP   = 5'd2;
    localparam logic [REG_W-1:0] REG_A0   = 5'd10;
    localparam logic [REG_W-1:0] REG_A1   = 5'd11;

    typedef enum logic [2:0] {PUSH, POP, POPRET, POPRETZ, MVSA01, MVA01S} seq_instr_e;

    typedef enum logic {IDLE, SEQ} seq_state_e;

    // Decoded view of a Zcmp instruction
    typedef struct packed {
        logic              legal;
        seq_instr_e        kind;
        logic [CNT_W-1:0]  n;         // registers in rlist
        logic [CNT_W-1:0]  last_idx;  // index of the final micro-op
        logic [IMM_W-1:0]  adj;       // stack adjustment in bytes
        logic [REG_W-1:0]  r1s;
        logic [REG_W-1:0]  r2s;
    } zcmp_info_t;

    // s-register field map: r'0,1 -> x8,x9; r'2..7 -> x18..x23
    function automatic logic [REG_W-1:0] sreg_map(input logic [2:0] rs);
        return (rs < 3'd2) ? {2'b01, rs} : (5'd16 + {2'b00, rs});
    endfunction

    // rlist position j (0 = ra, 1 = s0, 2 = s1, 3.. = s2..s11) to register number
    function automatic logic [REG_W-1:0] rlist_reg(input logic [CNT_W-1:0] j);
        if (j == 4'd0)      return REG_RA;
        else if (j == 4'd1) return 5'd8;
        else if (j == 4'd2) return 5'd9;
        else                return 5'd15 + {1'b0, j};
    endfunction

    function automatic logic [INSTR_W-1:0] enc_store(input logic [REG_W-1:0] rs2,
                                                     input logic [REG_W-1:0] rs1,
                                                     input logic [IMM_W-1:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPCODE_STORE};
    endfunction

    function automatic logic [INSTR_W-1:0] enc_load(input logic [REG_W-1:0] rd,
                                                    input logic [REG_W-1:0] rs1,
                                                    input logic [IMM_W-1:0] imm);
        return {imm, rs1, 3'b010, rd, OPCODE_LOAD};
    endfunction

    function automatic logic [INSTR_W-1:0] enc_addi(input logic [REG_W-1:0] rd,
                                                    input logic [REG_W-1:0] rs1,
                                                    input logic [IMM_W-1:0] imm);
        return {imm, rs1, 3'b000, rd, OPCODE_OPIMM};
    endfunction

    function automatic logic [INSTR_W-1:0] enc_jalr(input logic [REG_W-1:0] rd,
                                                    input logic [REG_W-1:0] rs1,
                                                    input logic [IMM_W-1:0] imm);
        return {imm, rs1, 3'b000, rd, OPCODE_JALR};
    endfunction

endpackage

// File: rtl/cv32e40s_sequencer_if.sv
// Instruction handshake between IF/ID register, sequencer and decoder.
// Upstream: instr_i, instr_is_compressed_i, valid_i -> ready_o.
// Downstream: instr_o, valid_o, seq_instr_o, seq_first_o, seq_last_o -> ready_i.
// slave = sequencer view, master = surrounding pipeline view.
interface cv32e40s_sequencer_if;
    import cv32e40s_pkg::*;

    logic [INSTR_W-1:0] instr_i;
    logic               instr_is_compressed_i;
    logic               valid_i;
    logic               ready_o;
    logic [INSTR_W-1:0] instr_o;
    logic               valid_o;
    logic               ready_i;
    logic               seq_instr_o;
    logic               seq_first_o;
    logic               seq_last_o;

    modport slave (
        input  instr_i, instr_is_compressed_i, valid_i, ready_i,
        output ready_o, instr_o, valid_o, seq_instr_o, seq_first_o, seq_last_o
    );

    modport master (
        output instr_i, instr_is_compressed_i, valid_i, ready_i,
        input  ready_o, instr_o, valid_o, seq_instr_o, seq_first_o, seq_last_o
    );

endinterface

// File: rtl/cv32e40s_zcmp_decode.sv
// Combinational Zcmp classifier: type, register count, stack adjustment,
// final micro-op index and legality from a 16-bit encoding.
// Ports: instr (16-bit encoding), compressed (encoding is 16-bit), info (decoded result).
module cv32e40s_zcmp_decode
    import cv32e40s_pkg::*;
(
    input  logic [15:0] instr,
    input  logic        compressed,
    output zcmp_info_t  info
);

    logic       is_cm;
    logic       is_pp;
    logic       is_mv;
    logic [3:0] rlist;
    logic [1:0] spimm;
    logic [4:0] n_plus3;
    logic [2:0] blocks;

    always_comb begin
        info.legal    = 1'b0;
        info.kind     = PUSH;
        info.n        = '0;
        info.last_idx = '0;
        info.adj      = '0;
        is_pp         = 1'b0;
        is_mv         = 1'b0;
        rlist         = instr[7:4];
        spimm         = instr[3:2];
        is_cm         = compressed && (instr[15:13] == 3'b101) && (instr[1:0] == 2'b10);

        case (instr[12:8])
            5'b11000: begin is_pp = 1'b1; info.kind = PUSH;    end
            5'b11010: begin is_pp = 1'b1; info.kind = POP;     end
            5'b11100: begin is_pp = 1'b1; info.kind = POPRETZ; end
            5'b11110: begin is_pp = 1'b1; info.kind = POPRET;  end
            default: ;
        endcase

        if (instr[12:10] == 3'b011) begin
            if (instr[6:5] == 2'b01) begin
                is_mv     = 1'b1;
                info.kind = MVSA01;
            end else if (instr[6:5] == 2'b11) begin
                is_mv     = 1'b1;
                info.kind = MVA01S;
            end
        end

        // rlist 15 skips s10 alone, so it maps to 13 registers
        info.n = (rlist == 4'd15) ? 4'd13 : (rlist - 4'd3);

        // 16-byte aligned save area plus spimm extra blocks
        n_plus3  = {1'b0, info.n} + 5'd3;
        blocks   = 3'(n_plus3 >> 2) + {1'b0, spimm};
        info.adj = IMM_W'({blocks, 4'b0000});

        case (info.kind)
            PUSH, POP: info.last_idx = info.n;
            POPRET:    info.last_idx = info.n + 4'd1;
            POPRETZ:   info.last_idx = info.n + 4'd2;
            default:   info.last_idx = 4'd1;
        endcase

        info.legal = is_cm && ((is_pp && (rlist >= 4'd4)) ||
                               (is_mv && (instr[9:7] != instr[4:2])));
    end

    assign info.r1s = sreg_map(instr[9:7]);
    assign info.r2s = sreg_map(instr[4:2]);

endmodule

// File: rtl/cv32e40s_sequencer.sv
// Zcmp micro-op sequencer between IF/ID and the decoder. Ordinary instructions
// pass through; legal push/pop/move forms are expanded into RV32I micro-ops.
// Ports: clk, rst (async, active-high), halt_i (freeze outputs/state),
// kill_i (abort to IDLE), bus (slave side of cv32e40s_sequencer_if).
module cv32e40s_sequencer
    import cv32e40s_pkg::*;
#(
    parameter bit ZC_EXT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                halt_i,
    input  logic                kill_i,
    cv32e40s_sequencer_if.slave bus
);

    zcmp_info_t         info;
    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               is_zcmp;
    logic               seq_mode;
    logic               is_last;
    logic               handshake;
    logic               valid;
    logic               ready;
    logic [INSTR_W-1:0] uop;
    logic [IMM_W-1:0]   mem_off;
    logic [CNT_W-1:0]   k_rel;
    logic [CNT_W-1:0]   list_idx;

    cv32e40s_zcmp_decode u_decode (
        .instr      (bus.instr_i[15:0]),
        .compressed (bus.instr_is_compressed_i),
        .info       (info)
    );

    assign is_zcmp = ZC_EXT && info.legal;

    // Micro-op for the current count; registers are visited highest-numbered first
    always_comb begin
        uop      = '0;
        mem_off  = IMM_W'({count_q, 2'b00}) + IMM_W'(4);
        k_rel    = count_q - info.n;
        list_idx = info.n - count_q - CNT_W'(1);
        case (info.kind)
            MVSA01: uop = (count_q == '0) ? enc_addi(info.r1s, REG_A0, '0)
                                          : enc_addi(info.r2s, REG_A1, '0);
            MVA01S: uop = (count_q == '0) ? enc_addi(REG_A0, info.r1s, '0)
                                          : enc_addi(REG_A1, info.r2s, '0);
            default: begin
                if (count_q < info.n) begin
                    if (info.kind == PUSH)
                        uop = enc_store(rlist_reg(list_idx), REG_SP, IMM_W'(0) - mem_off);
                    else
                        uop = enc_load(rlist_reg(list_idx), REG_SP, info.adj - mem_off);
                end else if (k_rel == '0) begin
                    uop = enc_addi(REG_SP, REG_SP,
                                   (info.kind == PUSH) ? (IMM_W'(0) - info.adj) : info.adj);
                end else if ((k_rel == CNT_W'(1)) && (info.kind == POPRETZ)) begin
                    uop = enc_addi(REG_A0, REG_ZERO, '0);
                end else begin
                    uop = enc_jalr(REG_ZERO, REG_RA, '0);
                end
            end
        endcase
    end

    // State and micro-op counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        seq_mode  = (state_q == SEQ) || (is_zcmp && bus.valid_i);
        valid     = bus.valid_i && !halt_i;
        handshake = valid && bus.ready_i;
        is_last   = seq_mode && (count_q == info.last_idx);
        ready     = seq_mode ? (handshake && is_last) : (bus.ready_i && !halt_i);

        if (kill_i) begin
            // kill wins over halt and any handshake in the same cycle
            ready   = 1'b1;
            state_d = IDLE;
            count_d = '0;
        end else if (seq_mode && handshake) begin
            if (is_last) begin
                state_d = IDLE;
                count_d = '0;
            end else begin
                state_d = SEQ;
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    assign bus.instr_o     = seq_mode ? uop : bus.instr_i;
    assign bus.valid_o     = valid;
    assign bus.ready_o     = ready;
    assign bus.seq_instr_o = seq_mode;
    assign bus.seq_first_o = seq_mode && (count_q == '0);
    assign bus.seq_last_o  = is_last;

endmodule
